// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file with a sequenced bulk-clear engine.
// Reads 1 cycle; no backpressure: writes and reads arriving while busy are dropped.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_conflict
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok_a, wr_ok_b;
    logic [DATA_W-1:0]   rdata_a, rdata_b;

    assign busy = (state == S_CLEAR);

    // A write to the hardwired-zero entry is treated as if it never happened.
    assign wr_ok_a = we_a && !busy && !(ZERO_REG && (wa_a == '0));
    assign wr_ok_b = we_b && !busy && !(ZERO_REG && (wa_b == '0));

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    state_nxt   = S_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Port B is assigned last so it wins a same-address write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr_ok_a) mem[wa_a] <= wd_a;
            if (wr_ok_b) mem[wa_b] <= wd_b;
        end
    end

    always_comb begin
        rdata_a = mem[ra_a];
        if (BYPASS && wr_ok_a && (wa_a == ra_a)) rdata_a = wd_a;
        if (BYPASS && wr_ok_b && (wa_b == ra_a)) rdata_a = wd_b;
        if (ZERO_REG && (ra_a == '0)) rdata_a = '0;
    end

    always_comb begin
        rdata_b = mem[ra_b];
        if (BYPASS && wr_ok_a && (wa_a == ra_b)) rdata_b = wd_a;
        if (BYPASS && wr_ok_b && (wa_b == ra_b)) rdata_b = wd_b;
        if (ZERO_REG && (ra_b == '0)) rdata_b = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_a        <= '0;
            rd_b        <= '0;
            rvalid_a    <= 1'b0;
            rvalid_b    <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            rvalid_a    <= re_a && !busy;
            rvalid_b    <= re_b && !busy;
            wr_conflict <= wr_ok_a && wr_ok_b && (wa_a == wa_b);
            if (re_a && !busy) rd_a <= rdata_a;
            if (re_b && !busy) rd_b <= rdata_b;
        end
    end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: vector table plus clear / reset-mid-clear sequences.
module tb_regfile_2w2r;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a, we_b, re_a, re_b, clr_req;
    logic [4:0]  wa_a, wa_b, ra_a, ra_b;
    logic [31:0] wd_a, wd_b;
    logic [31:0] rd_a, rd_b;
    logic        rvalid_a, rvalid_b, busy, wr_conflict;

    int n_vec  = 0;
    int n_fail = 0;

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .re_a(re_a), .ra_a(ra_a), .re_b(re_b), .ra_b(ra_b),
        .rd_a(rd_a), .rd_b(rd_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .clr_req(clr_req), .busy(busy), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we_a;
        logic [4:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [4:0]  wa_b;
        logic [31:0] wd_b;
        logic        re_a;
        logic [4:0]  ra_a;
        logic        re_b;
        logic [4:0]  ra_b;
        logic [31:0] x_rd_a;
        logic [31:0] x_rd_b;
        logic        x_rv_a;
        logic        x_rv_b;
        logic        x_conf;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we_a = 0; wa_a = 0; wd_a = 0;
        we_b = 0; wa_b = 0; wd_b = 0;
        re_a = 0; ra_a = 0; re_b = 0; ra_b = 0;
        clr_req = 0;
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a_addr, input logic [31:0] a_dat, input logic b_en,
                      input logic [4:0] b_addr, input logic [31:0] b_dat);
        idle_inputs();
        we_a = 1; wa_a = a_addr; wd_a = a_dat;
        we_b = b_en; wa_b = b_addr; wd_b = b_dat;
        step();
        idle_inputs();
    endtask

    task automatic rd2(input logic [4:0] a_addr, input logic [4:0] b_addr,
                       input logic [31:0] exp_a, input logic [31:0] exp_b, input string tag);
        idle_inputs();
        re_a = 1; ra_a = a_addr; re_b = 1; ra_b = b_addr;
        step();
        idle_inputs();
        chk({tag, " rd_a"}, rd_a, exp_a);
        chk({tag, " rd_b"}, rd_b, exp_b);
        chk({tag, " rvalid_a"}, {31'b0, rvalid_a}, 32'd1);
        chk({tag, " rvalid_b"}, {31'b0, rvalid_b}, 32'd1);
    endtask

    function automatic vec_t mk(input logic wea, input logic [4:0] waa, input logic [31:0] wda,
                                input logic web, input logic [4:0] wab, input logic [31:0] wdb,
                                input logic rea, input logic [4:0] raa,
                                input logic reb, input logic [4:0] rab,
                                input logic [31:0] xa, input logic [31:0] xb,
                                input logic xva, input logic xvb, input logic xc);
        vec_t v;
        v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
        v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
        v.re_a = rea; v.ra_a = raa; v.re_b = reb; v.ra_b = rab;
        v.x_rd_a = xa; v.x_rd_b = xb; v.x_rv_a = xva; v.x_rv_b = xvb; v.x_conf = xc;
        return v;
    endfunction

    // Steps while busy, attempting a write of 0x55@3 and reads each cycle; returns busy length.
    task automatic run_clear(output int cycles);
        cycles = 1;
        while (busy && cycles < 100) begin
            idle_inputs();
            we_a = 1; wa_a = 5'd3; wd_a = 32'h55;
            re_a = 1; ra_a = 5'd3; re_b = 1; ra_b = 5'd7;
            step();
            chk("busy rvalid_a", {31'b0, rvalid_a}, 32'd0);
            chk("busy rvalid_b", {31'b0, rvalid_b}, 32'd0);
            if (busy) cycles++;
        end
        idle_inputs();
    endtask

    initial begin
        int ncyc;
        idle_inputs();
        reset = 0;

        vt[0]  = mk(0, 0, 0,            0, 0, 0,            1, 1, 1, 17, 32'h0,        32'h0,        1, 1, 0);
        vt[1]  = mk(1, 1, 32'hAAAAAAAA, 1, 17, 32'hFFFFFFFF, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0);
        vt[2]  = mk(0, 0, 0,            0, 0, 0,            1, 1, 1, 17, 32'hAAAAAAAA, 32'hFFFFFFFF, 1, 1, 0);
        vt[3]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,  32'hAAAAAAAA, 32'hFFFFFFFF, 0, 0, 0);
        vt[4]  = mk(1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 0, 0,  32'hAAAAAAAA, 32'hFFFFFFFF, 0, 0, 1);
        vt[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,  32'hAAAAAAAA, 32'hFFFFFFFF, 0, 0, 0);
        vt[6]  = mk(0, 0, 0,            0, 0, 0,            1, 5, 1, 1,  32'h22222222, 32'hAAAAAAAA, 1, 1, 0);
        vt[7]  = mk(1, 9, 32'h12345678, 0, 0, 0,            1, 9, 1, 9,  32'h12345678, 32'h12345678, 1, 1, 0);
        vt[8]  = mk(1, 20, 32'h00000BAD, 1, 20, 32'h0000BEEF, 1, 20, 1, 20, 32'h0000BEEF, 32'h0000BEEF, 1, 1, 1);
        vt[9]  = mk(1, 0, 32'hDEADBEEF, 1, 0, 32'h0000CAFE, 1, 0, 1, 9,  32'h0,        32'h12345678, 1, 1, 0);
        vt[10] = mk(0, 0, 0,            0, 0, 0,            1, 0, 1, 20, 32'h0,        32'h0000BEEF, 1, 1, 0);
        vt[11] = mk(1, 6, 32'h77,       1, 7, 32'h88,       1, 6, 1, 7,  32'h77,       32'h88,       1, 1, 0);

        // Reset held low for two cycles
        step();
        step();
        chk("reset rd_a", rd_a, 32'h0);
        chk("reset rd_b", rd_b, 32'h0);
        chk("reset rvalid", {30'b0, rvalid_a, rvalid_b}, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset wr_conflict", {31'b0, wr_conflict}, 32'h0);
        reset = 1;
        step();

        for (int i = 0; i < 12; i++) begin
            we_a = vt[i].we_a; wa_a = vt[i].wa_a; wd_a = vt[i].wd_a;
            we_b = vt[i].we_b; wa_b = vt[i].wa_b; wd_b = vt[i].wd_b;
            re_a = vt[i].re_a; ra_a = vt[i].ra_a; re_b = vt[i].re_b; ra_b = vt[i].ra_b;
            step();
            chk($sformatf("vec%0d rd_a", i), rd_a, vt[i].x_rd_a);
            chk($sformatf("vec%0d rd_b", i), rd_b, vt[i].x_rd_b);
            chk($sformatf("vec%0d rvalid_a", i), {31'b0, rvalid_a}, {31'b0, vt[i].x_rv_a});
            chk($sformatf("vec%0d rvalid_b", i), {31'b0, rvalid_b}, {31'b0, vt[i].x_rv_b});
            chk($sformatf("vec%0d wr_conflict", i), {31'b0, wr_conflict}, {31'b0, vt[i].x_conf});
            chk($sformatf("vec%0d busy", i), {31'b0, busy}, 32'h0);
        end
        idle_inputs();

        // Bulk clear: fill 1..31, start clear alongside an accepted write/read
        for (int i = 1; i < 32; i += 2) begin
            wr(5'(i), 32'h01010101 * i, (i + 1 < 32), 5'(i + 1), 32'h01010101 * (i + 1));
        end
        rd2(5'd31, 5'd16, 32'h1F1F1F1F, 32'h10101010, "fill");

        idle_inputs();
        clr_req = 1;
        we_a = 1; wa_a = 5'd2; wd_a = 32'h99;
        re_b = 1; ra_b = 5'd2;
        step();
        idle_inputs();
        chk("clr start busy", {31'b0, busy}, 32'd1);
        chk("clr edge rd_b", rd_b, 32'h99);
        chk("clr edge rvalid_b", {31'b0, rvalid_b}, 32'd1);
        run_clear(ncyc);
        chk("clear busy cycles", ncyc, 32'd32);
        chk("clear done busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 32; i += 2) begin
            rd2(5'(i), 5'(i + 1), 32'h0, 32'h0, $sformatf("post-clear %0d", i));
        end

        // Reset in the middle of a clear
        wr(5'd30, 32'h5A, 1'b1, 5'd4, 32'hA5);
        rd2(5'd30, 5'd4, 32'h5A, 32'hA5, "pre-abort");
        clr_req = 1;
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        chk("mid-clear busy", {31'b0, busy}, 32'd1);
        reset = 0;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort rd_a", rd_a, 32'h0);
        chk("abort rd_b", rd_b, 32'h0);
        step();
        reset = 1;
        step();
        chk("after abort busy", {31'b0, busy}, 32'd0);
        rd2(5'd30, 5'd4, 32'h0, 32'h0, "after abort");
        wr(5'd12, 32'h1234, 1'b0, 5'd0, 32'h0);
        rd2(5'd12, 5'd12, 32'h1234, 32'h1234, "resume");

        // A fresh clear after the abort must again last exactly 32 cycles
        clr_req = 1;
        step();
        idle_inputs();
        run_clear(ncyc);
        chk("reclear busy cycles", ncyc, 32'd32);
        rd2(5'd12, 5'd1, 32'h0, 32'h0, "reclear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised two-write, two-read register file: the next generation of the team's four-address, two-output register file. Adds configurable width and depth, registered reads with valid strobes, and defined write-conflict priority. Also provides optional write-to-read bypass, an optional hardwired-zero entry 0, and a sequenced bulk-clear engine. It sits between the decode stage (read addresses) and the writeback stage (two write ports).

## Interface
- DATA_W, 32, width of each entry
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a read returns data being written to the same address on the same edge

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; storage and all state cleared while low
- we_a  in  1  write enable, port A
- wa_a  in  ADDR_W  write address, port A
- wd_a  in  DATA_W  write data, port A
- we_b  in  1  write enable, port B
- wa_b  in  ADDR_W  write address, port B
- wd_b  in  DATA_W  write data, port B
- re_a  in  1  read request, port A
- ra_a  in  ADDR_W  read address, port A
- re_b  in  1  read request, port B
- ra_b  in  ADDR_W  read address, port B
- rd_a  out  DATA_W  registered read data, port A
- rd_b  out  DATA_W  registered read data, port B
- rvalid_a  out  1  one-cycle strobe: rd_a updated
- rvalid_b  out  1  one-cycle strobe: rd_b updated
- clr_req  in  1  start bulk clear (level sampled in IDLE)
- busy  out  1  bulk clear in progress
- wr_conflict  out  1  one-cycle strobe: both ports wrote the same address

## Operation
- Reset (reset=0): all DEPTH entries 0; rd_a, rd_b = 0; rvalid_a, rvalid_b, busy, wr_conflict = 0; FSM in IDLE; clear counter 0.
- Writes: entry updated on the rising edge when we_x=1 and busy=0. Writes while busy=1 are dropped silently.
- Same-address writes: both we=1 and wa_a==wa_b means port B data is stored and wr_conflict=1 for the following cycle. Otherwise wr_conflict=0.
- ZERO_REG=1: writes to address 0 are discarded and do not raise wr_conflict. Reads of address 0 return 0.
- Reads: re_x=1 and busy=0 sampled on an edge means rd_x is loaded with the entry and rvalid_x=1 for one cycle. With re_x=0 or busy=1, rd_x holds its value and rvalid_x=0.
- Bypass (BYPASS=1): a read whose address matches an accepted write on the same edge returns the new data, port B over port A. With BYPASS=0 it returns the pre-write contents.
- FSM states:
  - IDLE: clr_req=1 moves to CLEAR with counter=0.
  - CLEAR: on each edge, entry[counter] is zeroed and the counter is incremented. On the edge that zeros entry DEPTH-1, move to IDLE and reset the counter to 0.
- clr_req is ignored in CLEAR. A held clr_req restarts a clear immediately after returning to IDLE.
- busy = (state == CLEAR).
- The counter is ADDR_W bits; completion is detected at counter == DEPTH-1, with no wrap past it.

## Timing
- Write-to-read latency: data written at edge N is readable by a request sampled at edge N+1, or at edge N with BYPASS=1.
- Read latency: 1 cycle. Request sampled at edge N gives rd_x/rvalid_x valid after edge N, for one cycle.
- Clear:
  - clr_req sampled at edge N sets busy=1 after edge N.
  - Entries 0..DEPTH-1 are zeroed at edges N+1..N+DEPTH.
  - busy=0 after edge N+DEPTH. busy is high for exactly DEPTH cycles.
- A write or read presented at the same edge clr_req is sampled is still accepted, because busy was 0.
- reset asserted mid-clear aborts immediately to IDLE with everything zero. Operation resumes on the first edge after deassertion.
- wr_conflict and rvalid_x never persist beyond one cycle without a new qualifying event.

## Test plan
- Reset then idle: reset low 2 cycles -> all outputs 0. Read of addresses 1 and 17 returns 0 with rvalid strobes.
- Basic dual write/read:
  - Write 0xAAAAAAAA@1 (A) and 0xFFFFFFFF@17 (B).
  - Next cycle read 1 and 17 -> rd_a=0xAAAAAAAA and rd_b=0xFFFFFFFF one cycle later, rvalid_a=rvalid_b=1 for one cycle.
- Conflict: A writes 0x11111111@5 and B writes 0x22222222@5 -> wr_conflict=1 one cycle; subsequent read of 5 = 0x22222222.
- Bypass and zero register:
  - Write 0x12345678@9 while reading 9 on the same edge -> rd_a=0x12345678 (BYPASS=1).
  - Write 0xDEADBEEF@0 -> read of 0 = 0, wr_conflict=0.
- Bulk clear:
  - Fill entries 1..31, then pulse clr_req -> busy high exactly 32 cycles.
  - A write of 0x55@3 during busy is dropped; a read request during busy gives rvalid=0.
  - After busy falls, reading any entry returns 0.
- Reset mid-clear: assert reset at clear cycle 10 -> busy=0 immediately. After release, all entries read 0 and a new write/read completes normally.
